// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic stream evaluator: FSM states,
// combining-function encodings and maximal-length LFSR tap masks.
package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sc_state_e;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_MUX = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    // Feedback mask for a right-shifting Fibonacci LFSR: fb = ^(state & mask).
    function automatic logic [15:0] sc_taps(input int width);
        case (width)
            32'd8:   return 16'h008D;
            32'd10:  return 16'h0081;
            32'd12:  return 16'h0053;
            32'd16:  return 16'hA011;
            default: return 16'h008D;
        endcase
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Right-shifting Fibonacci LFSR with seed load; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [15:0]      TAPS_ALL = sc_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb_s;

    // Next-state selection: load has priority over advance.
    always_comb begin
        fb_s = ^(state_q & TAPS);
        if (load_i) begin
            state_d = (seed_i == '0) ? ONE : seed_i;
        end else if (advance_i) begin
            state_d = {fb_s, state_q[WIDTH-1:1]};
        end else begin
            state_d = state_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= ONE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sc_stream_eval.sv
// Generates a stochastic bit stream by comparing rotated LFSR states against
// per-channel probabilities, combining the channel bits and counting the ones.
module sc_stream_eval
    import sc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 3,
    parameter int LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [WIDTH-1:0]        seed,
    input  logic [NUM_IN*WIDTH-1:0] prob,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    output logic                    bit_vld,
    output logic                    bit_out,
    output logic                    done,
    output logic [LEN_W-1:0]        count,
    output logic [WIDTH-1:0]        lfsr_state
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    sc_state_e               state_q;
    logic [1:0]              op_q;
    logic [NUM_IN*WIDTH-1:0] prob_q;
    logic [LEN_W-1:0]        remain_q;
    logic [LEN_W-1:0]        count_q;
    logic [LEN_W-1:0]        count_d;
    logic                    busy_q;
    logic                    vld_q;
    logic                    done_q;

    logic                    accept_s;
    logic                    advance_s;
    logic [WIDTH-1:0]        lfsr_s;
    logic [2*WIDTH-1:0]      dbl_s;
    logic [WIDTH-1:0]        rot_s [NUM_IN];
    logic [NUM_IN-1:0]       chan_s;
    logic                    comb_s;

    // rst_n is an active-high synchronous reset despite its name.
    assign accept_s  = (state_q == ST_IDLE) && start;
    assign advance_s = (state_q == ST_RUN);

    sc_lfsr #(
        .WIDTH(WIDTH)
    ) u_lfsr (
        .clk      (clk),
        .rst_i    (rst_n),
        .load_i   (accept_s),
        .seed_i   (seed),
        .advance_i(advance_s),
        .state_o  (lfsr_s)
    );

    // Channel comparators; rotl(s, i) is the upper half of {s, s} shifted left by i.
    always_comb begin
        dbl_s = {lfsr_s, lfsr_s};
        for (int i = 0; i < NUM_IN; i++) begin
            rot_s[i]  = dbl_s[2*WIDTH-1-i -: WIDTH];
            chan_s[i] = (rot_s[i] < prob_q[i*WIDTH +: WIDTH]);
        end
    end

    // Combining function over the channel bits.
    always_comb begin
        case (op_q)
            OP_AND:  comb_s = &chan_s;
            OP_OR:   comb_s = |chan_s;
            OP_MUX:  comb_s = lfsr_s[0] ? chan_s[1] : chan_s[0];
            OP_XOR:  comb_s = ^chan_s;
            default: comb_s = 1'b0;
        endcase
    end

    assign bit_out = vld_q & comb_s;
    assign count_d = count_q + LEN_W'(bit_out);

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            prob_q   <= '0;
            remain_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        prob_q   <= prob;
                        remain_q <= len;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            vld_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            vld_q   <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        vld_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    count_q <= count_d;
                    if (remain_q == LEN_ONE) begin
                        state_q <= ST_DONE;
                        vld_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        remain_q <= remain_q - LEN_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign bit_vld    = vld_q;
    assign done       = done_q;
    assign count      = count_q;
    assign lfsr_state = lfsr_s;

endmodule

// File: tb/tb_sc_stream_eval.sv
// Directed bench for sc_stream_eval (WIDTH=8, NUM_IN=3, LEN_W=8) with a
// reference-model scoreboard of expected stream bits.
module tb_sc_stream_eval;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [7:0]  seed;
    logic [23:0] prob;
    logic [7:0]  len;
    logic        busy;
    logic        bit_vld;
    logic        bit_out;
    logic        done;
    logic [7:0]  count;
    logic [7:0]  lfsr_state;

    int checks = 0;
    int errors = 0;
    bit sbq[$];

    sc_stream_eval #(
        .WIDTH (8),
        .NUM_IN(3),
        .LEN_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .seed      (seed),
        .prob      (prob),
        .len       (len),
        .busy      (busy),
        .bit_vld   (bit_vld),
        .bit_out   (bit_out),
        .done      (done),
        .count     (count),
        .lfsr_state(lfsr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pushes the expected bit stream and returns count / final state.
    task automatic model(input logic [7:0] sd, input logic [1:0] o, input logic [23:0] p,
                         input int n, output logic [7:0] cnt, output logic [7:0] fin,
                         output logic [7:0] init);
        logic [7:0] s;
        logic [7:0] r;
        bit c[3];
        bit b;
        s = (sd == 8'h00) ? 8'h01 : sd;
        init = s;
        cnt = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 3; i++) begin
                r = (s << i) | (s >> (8 - i));
                c[i] = (r < p[i*8 +: 8]);
            end
            case (o)
                2'd0:    b = c[0] & c[1] & c[2];
                2'd1:    b = c[0] | c[1] | c[2];
                2'd2:    b = s[0] ? c[1] : c[0];
                default: b = c[0] ^ c[1] ^ c[2];
            endcase
            sbq.push_back(b);
            cnt = cnt + {7'd0, b};
            s = {s[7] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
        end
        fin = s;
    endtask

    // Runs one full stream from a negedge in IDLE; inputs are scrambled while busy.
    task automatic do_stream(input logic [7:0] sd, input logic [1:0] o, input logic [23:0] p,
                             input int n);
        logic [7:0] ecnt;
        logic [7:0] efin;
        logic [7:0] einit;
        bit eb;
        model(sd, o, p, n, ecnt, efin, einit);
        start = 1'b1;
        seed  = sd;
        op    = o;
        prob  = p;
        len   = n[7:0];
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k == 1) chk("lfsr_loaded", lfsr_state, einit);
            chk("bit_vld_run", bit_vld, 1'b1);
            chk("busy_run", busy, 1'b1);
            if (sbq.size() > 0) begin
                eb = sbq.pop_front();
                chk("bit_out", bit_out, eb);
            end else begin
                chk("sbq_underflow", 1'b1, 1'b0);
            end
            seed = 8'($urandom);
            prob = 24'($urandom);
            op   = 2'($urandom);
            len  = 8'($urandom);
            @(negedge clk);
        end
        if (n == 0) chk("lfsr_loaded_len0", lfsr_state, einit);
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b1);
        chk("bit_vld_done", bit_vld, 1'b0);
        chk("bit_out_idle", bit_out, 1'b0);
        chk("count", count, ecnt);
        chk("lfsr_final", lfsr_state, efin);
        chk("sbq_empty", sbq.size(), 0);
        @(negedge clk);
        chk("busy_after", busy, 1'b0);
        chk("done_after", done, 1'b0);
        chk("count_hold", count, ecnt);
        chk("lfsr_hold", lfsr_state, efin);
    endtask

    initial begin
        logic [7:0] ecnt;
        logic [7:0] efin;
        logic [7:0] einit;
        bit eb;

        rst_n = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        seed  = 8'h00;
        prob  = 24'h0;
        len   = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vld", bit_vld, 1'b0);
        chk("rst_bit", bit_out, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", count, 8'h00);
        chk("rst_lfsr", lfsr_state, 8'h01);
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // OR with only channel 0 at 0x80: ones whenever the state is below 0x80.
        do_stream(8'h01, 2'd1, 24'h00_00_80, 255);
        chk("or_count_127", count, 8'd127);

        // AND of three 0xFF channels: zero only at state 0xFF; full period returns to 0x01.
        do_stream(8'h01, 2'd0, 24'hFF_FF_FF, 255);
        chk("and_count_254", count, 8'd254);
        chk("and_lfsr_01", lfsr_state, 8'h01);

        // Zero seed substitutes 1, one advance gives 0x80.
        do_stream(8'h00, 2'd3, 24'h12_34_56, 1);
        chk("seed0_lfsr_80", lfsr_state, 8'h80);

        // len == 0: immediate done, no bits.
        do_stream(8'h5C, 2'd1, 24'hFF_FF_FF, 0);
        chk("len0_count", count, 8'h00);

        // MUX and XOR with random operands.
        do_stream(8'($urandom), 2'd2, 24'($urandom), 200);
        do_stream(8'($urandom), 2'd3, 24'($urandom), 200);

        // Second start mid-RUN is ignored; reset aborts the stream.
        model(8'h5A, 2'd3, 24'h40_80_C0, 100, ecnt, efin, einit);
        start = 1'b1;
        seed  = 8'h5A;
        op    = 2'd3;
        prob  = 24'h40_80_C0;
        len   = 8'd100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("abort_vld", bit_vld, 1'b1);
            eb = sbq.pop_front();
            chk("abort_bit", bit_out, eb);
            if (k == 3) begin
                start = 1'b1;
                seed  = 8'h33;
                len   = 8'd5;
                op    = 2'd0;
            end
            if (k == 5) start = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        chk("abort_busy", busy, 1'b0);
        chk("abort_vld_low", bit_vld, 1'b0);
        chk("abort_count", count, 8'h00);
        chk("abort_lfsr", lfsr_state, 8'h01);
        for (int k = 0; k < 5; k++) begin
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", busy, 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_eval.md
SC_STREAM_EVAL -- requirements
Module: sc_stream_eval

Interface
REQ-001 Parameter WIDTH, default 8; LFSR width and width of each probability operand; legal values 8, 10, 12, 16.
REQ-002 Parameter NUM_IN, default 3; number of stochastic input channels; legal 2..4.
REQ-003 Parameter LEN_W, default 8; width of the stream-length and ones-count fields.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-high (asserted at 1); name kept per codebase convention.
REQ-006 start  input  1  request a new evaluation; sampled only in IDLE.
REQ-007 op  input  2  combining function: 0 AND, 1 OR, 2 MUX, 3 XOR.
REQ-008 seed  input  WIDTH  initial LFSR state.
REQ-009 prob  input  NUM_IN*WIDTH  channel i operand in bits [i*WIDTH +: WIDTH].
REQ-010 len  input  LEN_W  stream length in cycles.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 bit_vld  output  1  high in each RUN cycle.
REQ-013 bit_out  output  1  combined stochastic bit for the current RUN cycle.
REQ-014 done  output  1  one-cycle pulse in DONE.
REQ-015 count  output  LEN_W  number of 1s produced in the last completed stream.
REQ-016 lfsr_state  output  WIDTH  current LFSR register.

Function
REQ-017 States IDLE, RUN, DONE; IDLE->RUN on start with len!=0; IDLE->DONE on start with len==0; RUN->DONE after the len-th RUN cycle; DONE->IDLE unconditionally.
REQ-018 On start acceptance: latch op, prob and len; load LFSR with seed, or with 1 when seed==0; clear count.
REQ-019 LFSR is Fibonacci, shift right: next = {fb, s[WIDTH-1:1]}; for WIDTH=8, fb = s[7]^s[3]^s[2]^s[0]; taps for other widths come from the package, all maximal-length.
REQ-020 LFSR advances once per RUN cycle only; it holds its value in IDLE and DONE.
REQ-021 Channel i bit c_i = (rotl(s, i) < prob_i), unsigned compare, where rotl rotates left by i bits; channel 0 uses s unrotated.
REQ-022 bit_out: op0 = AND of all c_i; op1 = OR of all c_i; op2 = s[0] ? c_1 : c_0; op3 = XOR of all c_i.
REQ-023 bit_out is combinational from the current LFSR state and latched operands; bit_out is 0 when bit_vld is 0.
REQ-024 count increments by bit_out in each RUN cycle; it holds after DONE until the next accepted start.
REQ-025 Latency: start accepted in cycle T; RUN occupies T+1..T+len; done is high in T+len+1; busy is low in T+len+2.
REQ-026 start is ignored while busy; prob, op, len and seed changes while busy have no effect.
REQ-027 len==0: done pulses in T+1, count=0, no bit_vld, LFSR is loaded but not advanced.
REQ-028 Maximum len = 2^LEN_W-1; count cannot overflow.

Reset
REQ-029 While rst_n=1 at a clock edge: state=IDLE; busy=0, bit_vld=0, bit_out=0, done=0; count=0; lfsr_state=1; latched operands=0.
REQ-030 Reset mid-RUN aborts the stream; no done pulse follows, and count reads 0.

Structure
REQ-031 Package sc_pkg holds the state enum, the op encoding constants, and the tap-mask function indexed by WIDTH.
REQ-032 One sub-module, sc_lfsr (WIDTH; load, seed, advance, state), instantiated once.
REQ-033 Comparators and the combining function are inline in sc_stream_eval.

Verification (WIDTH=8, NUM_IN=3, LEN_W=8)
REQ-034 seed=0x01, op=1, prob={0x00,0x00,0x80}, len=255 -> 255 bit_vld cycles, count=127, done at T+256.
REQ-035 seed=0x01, op=0, all prob=0xFF, len=255 -> count=254 (0 only at state 0xFF); lfsr_state=0x01 after DONE.
REQ-036 seed=0x00, len=1 -> LFSR loads 0x01, and lfsr_state=0x80 after the single RUN cycle.
REQ-037 len=0 with start -> done in T+1, count=0, bit_vld never high.
REQ-038 Second start during RUN plus rst_n=1 asserted mid-stream -> second start ignored; after reset, IDLE with count=0 and no done pulse.
REQ-039 op=2 and op=3, random prob/seed, len=200 -> bit_out and count match the bench reference model cycle by cycle.
